muldiv_unit: RTL

Iterative multiply/divide unit with architectural HI/LO registers, parametrised in operand width. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO for the execute stage, alongside the single-cycle ALU. The pipeline starts an operation with a one-cycle `start` pulse and stalls on `busy`. Results are read from `hi`/`lo` (MFHI/MFLO); `cancel` aborts an in-flight operation on exception flush.

---
 rtl/muldiv_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  // Handshake: start is sampled only while busy=0; done pulses for one cycle
  // with hi/lo already holding the result; cancel drops CALC/FIN back to IDLE.
  state_t state_q, state_d;

  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     b_q;
  logic                 is_div_q, neg_res_q, neg_rem_q, dz_q;

  logic                 accept, fin_commit, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    accept     = (state_q == IDLE) && start && !cancel;
    fin_commit = (state_q == FIN) && !cancel;
    case (state_q)
      IDLE: if (accept && !op[2]) state_d = CALC;
      CALC: begin
        if (cancel)                  state_d = IDLE;
        else if (cnt_q == LAST_STEP) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operand magnitudes; the datapath only ever sees unsigned values.
  always_comb begin
    op_signed = !op[0];
    a_neg     = op_signed && src1[WIDTH-1];
    b_neg     = op_signed && src2[WIDTH-1];
    a_mag     = a_neg ? -src1 : src1;
    b_mag     = b_neg ? -src2 : src2;
  end

  // acc holds {partial product, remaining multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], div_ge};
  end

  // Remainder carries the dividend sign, so a zero divisor yields raw src1 in hi.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      done     <= fin_commit;
      div_zero <= fin_commit && is_div_q && dz_q;
      if (accept) begin
        case (op)
          3'b100: hi <= src1;
          3'b101: lo <= src1;
          3'b000, 3'b001, 3'b010, 3'b011: begin
            acc_q     <= {{WIDTH{1'b0}}, a_mag};
            b_q       <= b_mag;
            cnt_q     <= '0;
            is_div_q  <= op[1];
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dz_q      <= (src2 == '0);
          end
          default: ;
        endcase
      end
      if (state_q == CALC) begin
        acc_q <= is_div_q ? div_next : mul_next;
        cnt_q <= cnt_q + 1'b1;
      end
      if (fin_commit) begin
        if (is_div_q) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule
